// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register carrying a payload and a control word,
// with an optional two-entry skid buffer and a synchronous flush that squashes to bubbles.
//
// Handshake: a beat moves on a rising edge when valid and ready are both high on that
// port. While out_valid_o is high, the beat on out_data_o/out_ctrl_o stays put until
// out_ready_i takes it. A beat offered in a flush cycle is dropped regardless of in_ready_o.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 96,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o
);

  localparam bit USE_SKID = (SKID != 0);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              accept;
  logic              emit;

  assign out_valid_o = (state_q != S_EMPTY);

  // With the skid entry, ready comes straight from state flops; without it, ready
  // passes through out_ready_i so a full stage can be replaced in the same cycle.
  assign in_ready_o = USE_SKID ? (state_q != S_TWO)
                               : ((state_q == S_EMPTY) || out_ready_i);

  assign accept     = in_valid_i & in_ready_o;
  assign emit       = out_valid_o & out_ready_i;
  assign out_data_o = main_data_q;
  assign out_ctrl_o = out_valid_o ? main_ctrl_q : '0;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush_i) begin
      state_d     = S_EMPTY;
      main_ctrl_d = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d     = S_ONE;
            main_data_d = in_data_i;
            main_ctrl_d = in_ctrl_i;
          end
        end
        S_ONE: begin
          if (accept && emit) begin
            main_data_d = in_data_i;
            main_ctrl_d = in_ctrl_i;
          end else if (accept) begin
            state_d     = S_TWO;
            skid_data_d = in_data_i;
            skid_ctrl_d = in_ctrl_i;
          end else if (emit) begin
            state_d     = S_EMPTY;
            main_ctrl_d = '0;
          end
        end
        S_TWO: begin
          if (emit) begin
            state_d     = S_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: begin
          state_d     = S_EMPTY;
          main_ctrl_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance and a non-skid instance share stimulus,
// each with its own queue model of accepted-but-not-yet-emitted beats.
module tb_pipe_stage_reg;
  localparam int DW = 96;
  localparam int CW = 8;
  localparam int W  = DW + CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          out_ready_i = 1'b0;
  logic [DW-1:0] in_data_i = '0;
  logic [CW-1:0] in_ctrl_i = '0;

  logic          s_in_ready, s_out_valid, c_in_ready, c_out_valid;
  logic [DW-1:0] s_out_data, c_out_data;
  logic [CW-1:0] s_out_ctrl, c_out_ctrl;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_s[$];
  logic [W-1:0] exp_c[$];
  logic         s_rdy_m = 1'b0;
  logic         c_rdy_m = 1'b0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut_skid (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(s_in_ready),
    .in_data_i(in_data_i), .in_ctrl_i(in_ctrl_i),
    .out_valid_o(s_out_valid), .out_ready_i(out_ready_i),
    .out_data_o(s_out_data), .out_ctrl_o(s_out_ctrl)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut_comb (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(c_in_ready),
    .in_data_i(in_data_i), .in_ctrl_i(in_ctrl_i),
    .out_valid_o(c_out_valid), .out_ready_i(out_ready_i),
    .out_data_o(c_out_data), .out_ctrl_o(c_out_ctrl)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: compares on every emit, plus occupancy-derived valid/ready
  always @(negedge clk) begin
    if (rst_n) begin
      s_rdy_m = (exp_s.size() < 2);
      c_rdy_m = (exp_c.size() == 0) || out_ready_i;
      check("skid_out_valid", W'(s_out_valid), W'(exp_s.size() != 0));
      check("skid_in_ready", W'(s_in_ready), W'(s_rdy_m));
      check("comb_out_valid", W'(c_out_valid), W'(exp_c.size() != 0));
      check("comb_in_ready", W'(c_in_ready), W'(c_rdy_m));
      if (!s_out_valid) check("skid_ctrl_bubble", W'(s_out_ctrl), '0);
      if (!c_out_valid) check("comb_ctrl_bubble", W'(c_out_ctrl), '0);
      if (s_out_valid && out_ready_i && !flush_i) begin
        if (exp_s.size() == 0) check("skid_extra_beat", W'(1), W'(0));
        else check("skid_beat", {s_out_ctrl, s_out_data}, exp_s.pop_front());
      end
      if (c_out_valid && out_ready_i && !flush_i) begin
        if (exp_c.size() == 0) check("comb_extra_beat", W'(1), W'(0));
        else check("comb_beat", {c_out_ctrl, c_out_data}, exp_c.pop_front());
      end
    end
  end

  // model update: accepted beats join the queue, flush/reset empty it
  always @(negedge clk) begin
    #1;
    if (!rst_n || flush_i) begin
      exp_s.delete();
      exp_c.delete();
    end else if (in_valid_i) begin
      if (s_rdy_m) exp_s.push_back({in_ctrl_i, in_data_i});
      if (c_rdy_m) exp_c.push_back({in_ctrl_i, in_data_i});
    end
  end

  // driver tasks
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid_i  = v;
    in_data_i   = d;
    in_ctrl_i   = c;
    out_ready_i = ordy;
    flush_i     = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_skid_valid", W'(s_out_valid), '0);
    check("rst_skid_data", W'(s_out_data), '0);
    check("rst_skid_ctrl", W'(s_out_ctrl), '0);
    check("rst_skid_ready", W'(s_in_ready), W'(1));
    check("rst_comb_ready", W'(c_in_ready), W'(1));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // streaming 0x1..0x10
    for (int i = 1; i <= 16; i++) drive(1'b1, DW'(i), CW'(i), 1'b1, 1'b0);
    idle(3);

    // backpressure: A shown, three stall cycles, C held upstream
    drive(1'b1, DW'('hA), 8'h0A, 1'b1, 1'b0);
    drive(1'b1, DW'('hB), 8'h0B, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_shows_a", W'(s_out_data), W'('hA));
    drive(1'b1, DW'('hC), 8'h0C, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_ready_low", W'(s_in_ready), '0);
    drive(1'b1, DW'('hC), 8'h0C, 1'b0, 1'b0);
    drive(1'b1, DW'('hC), 8'h0C, 1'b1, 1'b0);
    @(negedge clk);
    check("bp_release_shows_a", W'(s_out_data), W'('hA));
    drive(1'b1, DW'('hC), 8'h0C, 1'b1, 1'b0);
    @(negedge clk);
    check("bp_ready_back", W'(s_in_ready), W'(1));
    idle(4);

    // flush in TWO with a new beat offered
    drive(1'b1, DW'('h5), 8'h15, 1'b0, 1'b0);
    drive(1'b1, DW'('h6), 8'h16, 1'b0, 1'b0);
    drive(1'b1, DW'('h7), 8'h17, 1'b0, 1'b1);
    @(negedge clk);
    check("flush_cycle_main", W'(s_out_data), W'('h5));
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    check("flush_valid", W'(s_out_valid), '0);
    check("flush_ctrl", W'(s_out_ctrl), '0);
    check("flush_ready", W'(s_in_ready), W'(1));
    idle(3);

    // combinational-ready mode: stall then replace without bubble
    drive(1'b1, DW'('h11), 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    check("comb_ready_empty", W'(c_in_ready), W'(1));
    drive(1'b1, DW'('h22), 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    check("comb_ready_stall", W'(c_in_ready), '0);
    drive(1'b1, DW'('h22), 8'h02, 1'b1, 1'b0);
    @(negedge clk);
    check("comb_ready_pass", W'(c_in_ready), W'(1));
    check("comb_shows_x", W'(c_out_data), W'('h11));
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    check("comb_replace", {c_out_valid, c_out_ctrl, c_out_data}, {1'b1, 8'h02, DW'('h22)});
    idle(4);

    // async reset while skid holds two entries
    drive(1'b1, DW'('h31), 8'h31, 1'b0, 1'b0);
    drive(1'b1, DW'('h32), 8'h32, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("pre_rst_full", W'(s_in_ready), '0);
    in_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", W'(s_out_valid), '0);
    check("midrst_data", W'(s_out_data), '0);
    check("midrst_ctrl", W'(s_out_ctrl), '0);
    check("midrst_ready", W'(s_in_ready), W'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // randomized traffic with ~5% flush
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom},
            ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 99) < 5);
    end
    idle(6);
    @(negedge clk);
    #2;
    check("drain_skid_empty", W'(exp_s.size()), '0);
    check("drain_comb_empty", W'(exp_c.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
